// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state type and index helper for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] g);
        return {g[3] | g[2], g[3] | g[1]};
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick starting the search at ptr
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] low;

    // rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation
    always_comb begin
        rot = 4'({req, req} >> ptr);
        low = rot & (~rot + 4'd1);
        idx = onehot_to_idx(low) + ptr;
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant lock and bounded hold time
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid,
    output logic             forced
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    state_t         state;
    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]    cnt;
    logic [IDX_W-1:0] pick;
    logic             any;

    rr_pick4 u_pick (
        .req(req),
        .ptr(ptr),
        .idx(pick),
        .any(any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            forced    <= 1'b0;
        end else if (state == IDLE) begin
            forced <= 1'b0;
            if (any) begin
                state     <= GRANT;
                gnt       <= 4'(1) << pick;
                gnt_id    <= pick;
                gnt_valid <= 1'b1;
                cnt       <= CW'(1);
                ptr       <= pick + 2'd1;
            end
        end else if (!(|(req & gnt)) || cnt == CW'(MAX_HOLD)) begin
            // every release goes through IDLE so the select bus gets a turnaround cycle
            state     <= IDLE;
            forced    <= |(req & gnt);
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: vector table, corner sequences and random traffic against a reference model
module tb_rr_arbiter4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'h0;
    logic [3:0] g  [3];
    logic [1:0] gi [3];
    logic       gv [3];
    logic       gf [3];

    int n_cmp = 0;
    int n_bad = 0;

    int own  [3];
    int cnt_m[3];
    int ptr_m[3];
    bit frc  [3];
    int mh   [3] = '{8, 2, 3};

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic [3:0] eg;
        logic       ef;
    } vec_t;
    vec_t tv[15];

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .req(req), .gnt(g[0]), .gnt_id(gi[0]), .gnt_valid(gv[0]), .forced(gf[0]));
    rr_arbiter4 #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .req(req), .gnt(g[1]), .gnt_id(gi[1]), .gnt_valid(gv[1]), .forced(gf[1]));
    rr_arbiter4 #(.MAX_HOLD(3)) dut3 (.clk(clk), .rst(rst), .req(req), .gnt(g[2]), .gnt_id(gi[2]), .gnt_valid(gv[2]), .forced(gf[2]));

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic [3:0] rq);
        if (r) begin
            own[i] = -1; cnt_m[i] = 0; ptr_m[i] = 0; frc[i] = 0;
        end else if (own[i] < 0) begin
            frc[i] = 0;
            for (int s = 0; s < 4; s++) begin
                int k;
                k = (ptr_m[i] + s) % 4;
                if (own[i] < 0 && rq[k]) begin
                    own[i] = k; cnt_m[i] = 1; ptr_m[i] = (k + 1) % 4;
                end
            end
        end else if (!rq[own[i]]) begin
            own[i] = -1; frc[i] = 0;
        end else if (cnt_m[i] == mh[i]) begin
            own[i] = -1; frc[i] = 1;
        end else begin
            cnt_m[i]++;
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, rq);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d_gnt", i), {4'h0, g[i]}, own[i] < 0 ? 8'h0 : 8'(1 << own[i]));
            chk($sformatf("m%0d_id", i), {6'h0, gi[i]}, own[i] < 0 ? 8'h0 : 8'(own[i]));
            chk($sformatf("m%0d_valid", i), {7'h0, gv[i]}, {7'h0, own[i] >= 0});
            chk($sformatf("m%0d_forced", i), {7'h0, gf[i]}, {7'h0, frc[i]});
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            own[i] = -1; cnt_m[i] = 0; ptr_m[i] = 0; frc[i] = 0;
        end
        // MAX_HOLD=2 instance: reset with all requesting, then rotation 0,1,2,3,0
        tv[0]  = '{1'b1, 4'hF, 4'h0, 1'b0};
        tv[1]  = '{1'b1, 4'hF, 4'h0, 1'b0};
        tv[2]  = '{1'b0, 4'hF, 4'h1, 1'b0};
        tv[3]  = '{1'b0, 4'hF, 4'h1, 1'b0};
        tv[4]  = '{1'b0, 4'hF, 4'h0, 1'b1};
        tv[5]  = '{1'b0, 4'hF, 4'h2, 1'b0};
        tv[6]  = '{1'b0, 4'hF, 4'h2, 1'b0};
        tv[7]  = '{1'b0, 4'hF, 4'h0, 1'b1};
        tv[8]  = '{1'b0, 4'hF, 4'h4, 1'b0};
        tv[9]  = '{1'b0, 4'hF, 4'h4, 1'b0};
        tv[10] = '{1'b0, 4'hF, 4'h0, 1'b1};
        tv[11] = '{1'b0, 4'hF, 4'h8, 1'b0};
        tv[12] = '{1'b0, 4'hF, 4'h8, 1'b0};
        tv[13] = '{1'b0, 4'hF, 4'h0, 1'b1};
        tv[14] = '{1'b0, 4'hF, 4'h1, 1'b0};
        for (int v = 0; v < 15; v++) begin
            apply(tv[v].r, tv[v].rq);
            chk($sformatf("tv%0d_gnt", v), {4'h0, g[1]}, {4'h0, tv[v].eg});
            chk($sformatf("tv%0d_forced", v), {7'h0, gf[1]}, {7'h0, tv[v].ef});
        end

        // single request on MAX_HOLD=8
        apply(1'b1, 4'h0);
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 4'h4);
            chk("single_gnt", {4'h0, g[0]}, 8'h04);
            chk("single_id", {6'h0, gi[0]}, 8'h02);
        end
        apply(1'b0, 4'h0);
        chk("single_rel_gnt", {4'h0, g[0]}, 8'h00);
        chk("single_rel_forced", {7'h0, gf[0]}, 8'h00);

        // fairness on MAX_HOLD=8: each owner drops for one cycle after 3 grant cycles
        apply(1'b1, 4'h0);
        for (int n = 0; n < 4; n++) begin
            logic [3:0] og;
            og = (n % 2) ? 4'h8 : 4'h1;
            for (int c = 0; c < 3; c++) begin
                apply(1'b0, 4'h9);
                chk("fair_gnt", {4'h0, g[0]}, {4'h0, og});
            end
            apply(1'b0, 4'h9 & ~og);
            chk("fair_gap", {4'h0, g[0]}, 8'h00);
        end

        // sole requester expiry on MAX_HOLD=3
        apply(1'b1, 4'h0);
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 3; c++) begin
                apply(1'b0, 4'h2);
                chk("sole_gnt", {4'h0, g[2]}, 8'h02);
            end
            apply(1'b0, 4'h2);
            chk("sole_idle", {4'h0, g[2]}, 8'h00);
            chk("sole_forced", {7'h0, gf[2]}, 8'h01);
        end

        // reset in the second cycle of a grant to requester 3
        apply(1'b1, 4'h0);
        apply(1'b0, 4'h8);
        chk("mid_gnt", {4'h0, g[0]}, 8'h08);
        apply(1'b1, 4'h8);
        chk("mid_rst_gnt", {4'h0, g[0]}, 8'h00);
        chk("mid_rst_ptr", {6'h0, dut8.ptr}, 8'h00);
        apply(1'b0, 4'hA);
        chk("mid_after_gnt", {4'h0, g[0]}, 8'h02);

        // random traffic; requests persist for a while so holds can expire
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
            apply($urandom_range(0, 127) == 0, rq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
